// File: rtl/hazard_scoreboard.sv
// Register/status-register hazard scoreboard: one countdown per architectural register
// plus one for the status register, stalling ID until pending writes are readable.
module hazard_scoreboard #(
  parameter int unsigned LAT   = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             id_wb,
  input  logic [3:0]       id_dest,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_s,
  input  logic             id_cond_used,
  output logic             hzrd,
  output logic [15:0]      busy_mask,
  output logic             sr_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] LatVal = 2'(LAT);

  logic [15:0][1:0]  cnt_q, cnt_d;
  logic [1:0]        sr_cnt_q, sr_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic src1_busy, src2_busy, sr_pend;
  logic issue;

  // Source checks read the pre-update counters, so an instruction never waits on itself.
  always_comb begin
    src1_busy = (cnt_q[id_src1] != 2'd0);
    src2_busy = (cnt_q[id_src2] != 2'd0);
    sr_pend   = (sr_cnt_q != 2'd0);
    hzrd      = id_valid & (src1_busy | (id_two_src & src2_busy) | (id_cond_used & sr_pend));
    issue     = id_valid & ~hzrd & ~flush & ~freeze;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!freeze) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (cnt_q[i] != 2'd0) begin
          cnt_d[i] = cnt_q[i] - 2'd1;
        end
        if (issue && id_wb && (id_dest == 4'(i))) begin
          cnt_d[i] = LatVal;
        end
      end
    end
  end

  always_comb begin
    sr_cnt_d = sr_cnt_q;
    if (!freeze) begin
      if (sr_cnt_q != 2'd0) begin
        sr_cnt_d = sr_cnt_q - 2'd1;
      end
      if (issue && id_s) begin
        sr_cnt_d = LatVal;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hzrd && !freeze && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      sr_cnt_q    <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sr_cnt_q    <= sr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      busy_mask[i] = (cnt_q[i] != 2'd0);
    end
  end

  assign sr_busy   = sr_pend;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter LAT, default 3, meaning cycles from issue until the written register value is readable from the register file (legal 1..3).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the stall statistics counter.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port freeze  input  1  pipeline frozen (memory stall): no issue, no aging.
REQ-006 The block SHALL have port flush  input  1  instruction in ID is killed (taken branch in EXE).
REQ-007 The block SHALL have port id_valid  input  1  ID holds a valid instruction.
REQ-008 The block SHALL have port id_wb  input  1  ID instruction writes a destination register.
REQ-009 The block SHALL have port id_dest  input  4  destination register index.
REQ-010 The block SHALL have port id_src1  input  4  first source index (rn).
REQ-011 The block SHALL have port id_src2  input  4  second source index (rm, or rd for stores).
REQ-012 The block SHALL have port id_two_src  input  1  id_src2 is actually read.
REQ-013 The block SHALL have port id_s  input  1  ID instruction updates the status register.
REQ-014 The block SHALL have port id_cond_used  input  1  ID instruction condition is not AL (reads status register).
REQ-015 The block SHALL have port hzrd  output  1  stall ID this cycle, combinational.
REQ-016 The block SHALL have port busy_mask  output  16  bit i set when register i has a pending write.
REQ-017 The block SHALL have port sr_busy  output  1  status register update pending.
REQ-018 The block SHALL have port stall_cnt  output  CNT_W  saturating count of hazard stall cycles.

Function
REQ-019 The block SHALL hold one 2-bit countdown counter per register (16) plus one for the status register (sr_cnt).
REQ-020 hzrd SHALL equal id_valid & ((cnt[id_src1]!=0) | (id_two_src & cnt[id_src2]!=0) | (id_cond_used & sr_cnt!=0)).
REQ-021 issue SHALL equal id_valid & ~hzrd & ~flush & ~freeze.
REQ-022 When freeze=1, all counters and stall_cnt SHALL hold their values; hzrd SHALL still be computed.
REQ-023 When freeze=0, each nonzero counter SHALL decrement by 1 per cycle; zero counters SHALL stay zero (no wrap).
REQ-024 On issue with id_wb=1, cnt[id_dest] SHALL load LAT on the next edge, overriding a same-cycle decrement of that entry.
REQ-025 On issue with id_s=1, sr_cnt SHALL load LAT on the next edge, overriding a same-cycle decrement.
REQ-026 flush=1 SHALL suppress the load for the ID instruction; in-flight entries SHALL continue aging unchanged.
REQ-027 A source equal to id_dest of the same instruction SHALL not self-stall (check uses pre-update counters).
REQ-028 busy_mask[i] SHALL equal (cnt[i]!=0); sr_busy SHALL equal (sr_cnt!=0).
REQ-029 stall_cnt SHALL increment by 1 on each edge where hzrd=1 and freeze=0, saturating at all-ones.
REQ-030 A dependent instruction SHALL therefore stall exactly LAT cycles after its producer issues back-to-back.

Reset
REQ-031 On rst=0, asynchronously, all 17 counters and stall_cnt SHALL clear to 0, so busy_mask=0, sr_busy=0, hzrd=0.
REQ-032 Reset asserted mid-operation SHALL discard all pending entries; first edge after release SHALL behave as from empty.

Verification
REQ-033 Issue r3<-r1+r2 (wb, LAT=3), next cycle src1=r3 -> hzrd=1 for 3 cycles, busy_mask=0x0008 then 0; stall_cnt=3.
REQ-034 Issue with id_s=1, next instruction id_cond_used=1, srcs free -> hzrd=1 for 3 cycles via sr_busy; id_cond_used=0 -> no stall.
REQ-035 Issue r5 producer, freeze=1 for 4 cycles -> cnt[5] holds at 3, busy_mask=0x0020 throughout, stall_cnt unchanged.
REQ-036 Producer to r7 with flush=1 same cycle -> busy_mask stays 0; consumer of r7 next cycle sees hzrd=0.
REQ-037 Issue r4 when cnt[4]=1 (write-after-write) -> cnt[4]=3 next cycle, not 0; id_two_src=0 with id_src2=r4 -> no stall.
REQ-038 Force stall_cnt to all-ones with CNT_W=4 (15 stalls), more stalls -> stays 15; rst=0 mid-count -> all outputs 0 immediately.
